uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx instance between NUM_REQ byte producers (debug console, CPU OUT port, etc.).
//  Round-robin arbitration with optional packet lock: a grantee keeps the UART until it sends a byte with last=1.
//  Sequences the uart_tx load/send handshake: in_enable, then send_data, then waits for busyFlag to rise and fall.
//  Sits between the requester fabric and uart_tx; tx_* ports connect directly to uart_tx in_enable/send_data/bus/busyFlag.
// PARAMETERS
//  NUM_REQ      4  number of requesters, 2..8; GW = $clog2(NUM_REQ) (localparam)
//  LOCK_EN      1  1: hold grant until last byte accepted; 0: re-arbitrate after every byte
//  BUSY_TIMEOUT 4  cycles in WAIT_BUSY with tx_busy=0 before abort and error, 1..15
// PORTS
//  clk           in   1          system clock
//  reset         in   1          synchronous, active-high
//  req_valid     in   NUM_REQ    per-requester byte valid
//  req_data      in   8*NUM_REQ  byte of requester i at [8i+7:8i]
//  req_last      in   NUM_REQ    byte is last of packet (used only when LOCK_EN=1)
//  req_ready     out  NUM_REQ    one-hot accept; byte transferred when valid&ready
//  tx_in_enable  out  1          to uart_tx in_enable; one-cycle pulse, bus is latched
//  tx_send_data  out  1          to uart_tx send_data; one-cycle pulse
//  tx_bus        out  8          to uart_tx bus; holds captured byte
//  tx_busy       in   1          from uart_tx busyFlag
//  grant_valid   out  1          a requester holds the lock (packet in progress)
//  grant_id      out  GW         current or last grantee index
//  err_no_busy   out  1          sticky: tx_busy never rose after send; cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=0, tx_in_enable=0, tx_send_data=0, tx_bus=0, grant_valid=0, grant_id=0,
//   err_no_busy=0, rr_ptr=0, timeout counter=0.
//  FSM IDLE -> LOAD -> FIRE -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//  IDLE: if tx_busy=1, no grant; hold. Else select g:
//   - lock held: g=grant_id; wait for req_valid[g]; other requesters are ignored.
//   - no lock: first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   req_ready[g]=1 combinationally in the same cycle (only when valid); byte captured into tx_bus;
//   grant_id<=g; go to LOAD. No valid requester: stay in IDLE, req_ready=0.
//  Lock update on accept: LOCK_EN=1 and last=0 -> grant_valid<=1. last=1 or LOCK_EN=0 -> grant_valid<=0,
//   rr_ptr<=(g+1) mod NUM_REQ.
//  LOAD: tx_in_enable=1 for exactly one cycle -> FIRE.
//  FIRE: tx_send_data=1 for exactly one cycle; clear counter -> WAIT_BUSY.
//  WAIT_BUSY: tx_busy=1 -> WAIT_DONE; else counter++; counter reaches BUSY_TIMEOUT -> err_no_busy<=1,
//   grant_valid<=0, rr_ptr<=grant_id+1, -> IDLE (byte dropped).
//  WAIT_DONE: stay while tx_busy=1; tx_busy=0 -> IDLE. send_data is never high here, so uart_tx
//   returns from STOP to IDLE rather than chaining.
//  Latency: accept at cycle t -> tx_in_enable at t+1, tx_send_data at t+2; busy expected at t+3.
//   Next accept no earlier than the cycle after tx_busy falls (back-to-back frame gap = 1 idle cycle + 2).
//  Only one req_ready bit is ever high; req_ready is 0 in every state except IDLE.
//  tx_bus holds its value until the next accept; req_data changes after accept have no effect.
//  Wrap-around: rr_ptr from NUM_REQ-1 goes to 0. With NUM_REQ not a power of 2, indices >= NUM_REQ are never granted.
//  Reset mid-frame: all state cleared as above on the next edge; uart_tx shares reset. If tx_busy is
//   still 1 after reset (e.g. separate reset), IDLE waits for tx_busy=0 before granting.
// TESTING
//  1 Single byte: req0 valid, data=0x55, last=1 -> ready[0] at t, tx_in_enable t+1 with tx_bus=0x55,
//    tx_send_data t+2; frame on uart_tx pin 0,10101010,1 (LSB first); grant_valid stays 0.
//  2 Round robin: req0..3 all valid, last=1, each holding a different byte -> grant order 0,1,2,3,0;
//    no grant while tx_busy=1.
//  3 Packet lock: req1 sends 0xA1,0xA2(last) while req2 valid with 0xB0 -> UART order A1,A2,B0;
//    req2 gets no ready while grant_valid=1.
//  4 LOCK_EN=0: same stimulus as 3 -> order A1,B0,A2.
//  5 Timeout: stub tx_busy tied 0 -> after FIRE + BUSY_TIMEOUT (4) cycles err_no_busy=1,
//    FSM returns to IDLE, next requester served.
//  6 Reset mid-frame: assert reset during data bit 3 -> all outputs 0 next cycle, txPin=1,
//    a new req byte after reset transmits correctly.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte sources, with optional packet lock.
// Accept at t -> tx_in_enable t+1, tx_send_data t+2; req_ready only in IDLE while the UART is idle.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_EN      = 1,
  parameter int BUSY_TIMEOUT = 4,
  localparam int GW          = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_in_enable,
  output logic                 tx_send_data,
  output logic [7:0]           tx_bus,
  input  logic                 tx_busy,
  output logic                 grant_valid,
  output logic [GW-1:0]        grant_id,
  output logic                 err_no_busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_FIRE      = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;

  logic [2:0]    state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] sel_idx;
  logic          sel_found;
  logic          accept;
  logic [3:0]    busy_cnt;
  int            idx;

  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] i);
    if (int'(i) >= NUM_REQ - 1) return '0;
    return i + GW'(1);
  endfunction

  // Lock pins the choice to the current grantee; otherwise search upward from rr_ptr,
  // iterating backwards so the lowest offset wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = grant_id;
    idx       = 0;
    if (grant_valid) begin
      sel_found = req_valid[grant_id];
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (req_valid[idx]) begin
          sel_found = 1'b1;
          sel_idx   = idx[GW-1:0];
        end
      end
    end
  end

  assign accept       = !reset && (state == S_IDLE) && !tx_busy && sel_found;
  assign req_ready    = accept ? (NUM_REQ'(1) << sel_idx) : '0;
  assign tx_in_enable = (state == S_LOAD);
  assign tx_send_data = (state == S_FIRE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      tx_bus      <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      err_no_busy <= 1'b0;
      rr_ptr      <= '0;
      busy_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            tx_bus   <= req_data[8*sel_idx +: 8];
            grant_id <= sel_idx;
            if ((LOCK_EN != 0) && !req_last[sel_idx]) begin
              grant_valid <= 1'b1;
            end else begin
              grant_valid <= 1'b0;
              rr_ptr      <= next_idx(sel_idx);
            end
            state <= S_LOAD;
          end
        end
        S_LOAD: state <= S_FIRE;
        S_FIRE: begin
          busy_cnt <= '0;
          state    <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (busy_cnt == 4'(BUSY_TIMEOUT - 1)) begin
            // UART never started: drop the byte and release any packet lock
            err_no_busy <= 1'b1;
            grant_valid <= 1'b0;
            rr_ptr      <= next_idx(grant_id);
            state       <= S_IDLE;
          end else begin
            busy_cnt <= busy_cnt + 4'd1;
          end
        end
        S_WAIT_DONE: if (!tx_busy) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: one locked and one unlocked instance, each driving a behavioural uart_tx;
// expected bytes are queued at stimulus time and compared against frames decoded from the serial pin.
module tb_uart_tx_arbiter;
  localparam int BITC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int checks = 0;
  int passes = 0;
  int viol   = 0;

  logic [8:0] sq [8][$];
  logic [7:0] exp_q [2][$];
  logic       stub_dead [2];

  wire [3:0] rdy_w [2];
  wire [3:0] rv_w  [2];
  wire       ien_w [2];
  wire       snd_w [2];
  wire [7:0] bus_w [2];
  wire       busy_w [2];
  wire       pin_w [2];
  wire       gv_w  [2];
  wire [1:0] gid_w [2];
  wire       err_w [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  for (genvar u = 0; u < 2; u++) begin : g_u
    logic [3:0]  rv;
    logic [3:0]  rl;
    logic [31:0] rd;
    logic        busy_r = 1'b0;
    logic        pin_r  = 1'b1;
    logic [7:0]  hold;
    logic [9:0]  frame;
    int          cnt;
    logic        rx_on;
    int          rc;
    logic [9:0]  rxb;

    uart_tx_arbiter #(.NUM_REQ(4), .LOCK_EN(u == 0 ? 1 : 0), .BUSY_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(rv), .req_data(rd), .req_last(rl), .req_ready(rdy_w[u]),
      .tx_in_enable(ien_w[u]), .tx_send_data(snd_w[u]), .tx_bus(bus_w[u]), .tx_busy(busy_r),
      .grant_valid(gv_w[u]), .grant_id(gid_w[u]), .err_no_busy(err_w[u])
    );
    assign busy_w[u] = busy_r;
    assign pin_w[u]  = pin_r;
    assign rv_w[u]   = rv;

    // uart_tx stand-in: latch on in_enable, 10-bit frame of BITC cycles per bit on send_data
    always @(posedge clk) begin
      if (reset) begin
        busy_r <= 1'b0; pin_r <= 1'b1; cnt <= 0; hold <= 8'h00; frame <= 10'h0;
      end else begin
        if (ien_w[u]) hold <= bus_w[u];
        if (!busy_r) begin
          if (snd_w[u] && !stub_dead[u]) begin
            busy_r <= 1'b1; frame <= {1'b1, hold, 1'b0}; cnt <= 0; pin_r <= 1'b0;
          end
        end else if (cnt == 10*BITC - 1) begin
          busy_r <= 1'b0; pin_r <= 1'b1;
        end else begin
          cnt <= cnt + 1; pin_r <= frame[(cnt + 1) / BITC];
        end
      end
    end

    // Producer: each requester presents the head of its queue until accepted
    initial begin
      logic [3:0] acc;
      rv = 4'h0; rl = 4'h0; rd = {4{8'hEE}};
      forever begin
        @(negedge clk);
        acc = reset ? 4'h0 : (rv & rdy_w[u]);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
          if (acc[i]) void'(sq[u*4+i].pop_front());
          if (sq[u*4+i].size() != 0) begin
            rv[i] = 1'b1; rd[8*i +: 8] = sq[u*4+i][0][7:0]; rl[i] = sq[u*4+i][0][8];
          end else begin
            rv[i] = 1'b0; rd[8*i +: 8] = 8'hEE; rl[i] = 1'b0;
          end
        end
      end
    end

    // Serial decoder and scoreboard pop
    initial begin
      rx_on = 1'b0; rc = 0; rxb = 10'h0;
      forever begin
        @(negedge clk);
        if (reset) begin
          rx_on = 1'b0;
        end else if (!rx_on) begin
          if (pin_r == 1'b0) begin rx_on = 1'b1; rc = 0; end
        end else begin
          rc++;
          if (rc % BITC == BITC/2) rxb[rc / BITC] = pin_r;
          if (rc == 9*BITC + BITC/2) begin
            rx_on = 1'b0;
            chk($sformatf("frame_fmt_u%0d", u), {rxb[9], rxb[0]}, 2'b10);
            if (exp_q[u].size() == 0) begin
              checks++;
              $display("FAIL unexpected_byte_u%0d: got %02h required none", u, rxb[8:1]);
            end else begin
              chk($sformatf("byte_u%0d", u), rxb[8:1], exp_q[u].pop_front());
            end
          end
        end
      end
    end

    // Continuous protocol invariants, tallied and compared once at the end
    initial forever begin
      @(negedge clk);
      if (!reset) begin
        if (rdy_w[u] != 4'h0 && busy_r) viol++;
        if (!$onehot0(rdy_w[u])) viol++;
        if (rdy_w[u] != 4'h0 && (ien_w[u] || snd_w[u])) viol++;
        if (gv_w[u] && rdy_w[u] != 4'h0 && rdy_w[u] != (4'b1 << gid_w[u])) viol++;
      end
    end
  end

  function automatic logic [17:0] outs(input int u);
    return {rdy_w[u], ien_w[u], snd_w[u], bus_w[u], gv_w[u], gid_w[u], err_w[u]};
  endfunction

  task automatic wait_ready(input int u, input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk);
      seen = (rdy_w[u] != 4'h0);
    end
    chk(name, seen, 1'b1);
  endtask

  task automatic drain(input int u, input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      done = (exp_q[u].size() == 0) && (rv_w[u] == 4'h0) && !busy_w[u] &&
             (sq[u*4].size() + sq[u*4+1].size() + sq[u*4+2].size() + sq[u*4+3].size() == 0);
    end
    chk(name, done, 1'b1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    stub_dead[0] = 1'b0;
    stub_dead[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_u0", outs(0), 18'h0);
    chk("reset_u1", outs(1), 18'h0);
    reset = 1'b0;

    // Single byte, cycle-exact handshake
    sq[0].push_back({1'b1, 8'h55}); exp_q[0].push_back(8'h55);
    wait_ready(0, "t1_wait_ready");
    chk("t1_ready", {rdy_w[0], ien_w[0], snd_w[0]}, {4'b0001, 2'b00});
    @(negedge clk);
    chk("t1_load", {ien_w[0], snd_w[0], bus_w[0]}, {2'b10, 8'h55});
    @(negedge clk);
    chk("t1_fire", {ien_w[0], snd_w[0], bus_w[0]}, {2'b01, 8'h55});
    @(negedge clk);
    chk("t1_busy_gv_gid", {busy_w[0], gv_w[0], gid_w[0]}, {1'b1, 1'b0, 2'd0});
    drain(0, "t1_drain");

    // Round robin from rr_ptr=0: 0,1,2,3,0
    pulse_reset();
    sq[0].push_back({1'b1, 8'h10}); sq[0].push_back({1'b1, 8'h11});
    sq[1].push_back({1'b1, 8'h21}); sq[2].push_back({1'b1, 8'h32}); sq[3].push_back({1'b1, 8'h43});
    exp_q[0].push_back(8'h10); exp_q[0].push_back(8'h21); exp_q[0].push_back(8'h32);
    exp_q[0].push_back(8'h43); exp_q[0].push_back(8'h11);
    drain(0, "t2_drain");

    // Packet lock: A1,A2 from req1 before B0 from req2
    sq[1].push_back({1'b0, 8'hA1}); sq[1].push_back({1'b1, 8'hA2}); sq[2].push_back({1'b1, 8'hB0});
    exp_q[0].push_back(8'hA1); exp_q[0].push_back(8'hA2); exp_q[0].push_back(8'hB0);
    wait_ready(0, "t3_wait_ready");
    chk("t3_first_grant", rdy_w[0], 4'b0010);
    @(negedge clk);
    chk("t3_lock", {gv_w[0], gid_w[0]}, {1'b1, 2'd1});
    drain(0, "t3_drain");

    // Same stimulus without lock: A1,B0,A2
    sq[5].push_back({1'b0, 8'hA1}); sq[5].push_back({1'b1, 8'hA2}); sq[6].push_back({1'b1, 8'hB0});
    exp_q[1].push_back(8'hA1); exp_q[1].push_back(8'hB0); exp_q[1].push_back(8'hA2);
    wait_ready(1, "t4_wait_ready");
    chk("t4_first_grant", rdy_w[1], 4'b0010);
    @(negedge clk);
    chk("t4_no_lock", gv_w[1], 1'b0);
    drain(1, "t4_drain");

    // Timeout with a dead UART while a packet lock is held
    stub_dead[0] = 1'b1;
    sq[3].push_back({1'b0, 8'h77});
    wait_ready(0, "t5_wait_ready");
    chk("t5_grant", rdy_w[0], 4'b1000);
    repeat (6) @(negedge clk);
    chk("t5_before_timeout", {err_w[0], gv_w[0]}, 2'b01);
    @(negedge clk);
    chk("t5_timeout", {err_w[0], gv_w[0]}, 2'b10);
    stub_dead[0] = 1'b0;
    sq[1].push_back({1'b1, 8'h99}); sq[3].push_back({1'b1, 8'h7A});
    exp_q[0].push_back(8'h99); exp_q[0].push_back(8'h7A);
    drain(0, "t5_drain");
    chk("t5_err_sticky", err_w[0], 1'b1);

    // Reset during data bit 3
    sq[2].push_back({1'b1, 8'hC8}); exp_q[0].push_back(8'hC8);
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk);
      seen = snd_w[0];
    end
    chk("t6_send_seen", seen, 1'b1);
    repeat (18) @(negedge clk);
    chk("t6_mid_bit3", pin_w[0], 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_reset_outs_u0", outs(0), 18'h0);
    chk("t6_reset_pin", {pin_w[0], busy_w[0]}, 2'b10);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q[0].delete();
    sq[2].push_back({1'b1, 8'h5A}); exp_q[0].push_back(8'h5A);
    drain(0, "t6_drain");

    chk("invariants", viol, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
